// File: rtl/adaptive_filter_seq.sv
// Frame sequencer for the 33-tap adaptive filter: owns the tap delay line, drives
// the datapath enable through the MAC window and hands the error sample downstream.
module adaptive_filter_seq #(
  parameter int DW          = 14,
  parameter int TAPS        = 33,
  parameter int RUN_CYCLES  = 34,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DW-1:0]      s_data,
  output logic               filt_en,
  output logic [TAPS*DW-1:0] taps_flat,
  input  logic               div_state,
  input  logic [DW-1:0]      e_in,
  output logic [DW-1:0]      e_out,
  output logic               e_valid,
  input  logic               e_ready,
  output logic               busy,
  output logic               timeout_err,
  input  logic               err_clr,
  output logic [15:0]        frame_cnt
);

  // state    | meaning
  // IDLE     | ready for a sample; datapath disabled
  // RUN      | datapath enabled for the MAC/accumulate window
  // WAIT_DIV | enabled, waiting for divider completion or timeout
  // CAPTURE  | one extra enabled cycle, then latch e
  // OUT      | datapath disabled (re-arms), error offered downstream
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RUN      = 3'd1;
  localparam logic [2:0] S_WAIT_DIV = 3'd2;
  localparam logic [2:0] S_CAPTURE  = 3'd3;
  localparam logic [2:0] S_OUT      = 3'd4;

  localparam int RW = $clog2(RUN_CYCLES + 1);
  localparam int WW = $clog2(DIV_TIMEOUT + 1);

  logic [2:0]    state;
  logic [RW-1:0] run_cnt;
  logic [WW-1:0] wait_cnt;
  logic [DW-1:0] taps [TAPS];

  always_ff @(posedge clk) begin
    if (rstn) begin
      state       <= S_IDLE;
      run_cnt     <= '0;
      wait_cnt    <= '0;
      e_out       <= '0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
      for (int k = 0; k < TAPS; k++) taps[k] <= '0;
    end else begin
      // a timeout set later in this block overrides the clear
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (s_valid) begin
            for (int k = TAPS - 1; k > 0; k--) taps[k] <= taps[k-1];
            taps[0] <= s_data;
            run_cnt <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          run_cnt <= run_cnt + RW'(1);
          if (run_cnt == RW'(RUN_CYCLES - 1)) begin
            wait_cnt <= '0;
            state    <= S_WAIT_DIV;
          end
        end
        S_WAIT_DIV: begin
          if (div_state) begin
            state <= S_CAPTURE;
          end else if (wait_cnt == WW'(DIV_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_CAPTURE: begin
          e_out <= e_in;
          state <= S_OUT;
        end
        S_OUT: begin
          if (e_ready) begin
            frame_cnt <= frame_cnt + 16'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign s_ready = (state == S_IDLE);
  assign busy    = (state != S_IDLE);
  assign e_valid = (state == S_OUT);
  assign filt_en = (state == S_RUN) || (state == S_WAIT_DIV) || (state == S_CAPTURE);

  always_comb begin
    taps_flat = '0;
    for (int k = 0; k < TAPS; k++) taps_flat[k*DW +: DW] = taps[k];
  end

endmodule

// File: tb/tb_adaptive_filter_seq.sv
// Scoreboard bench for adaptive_filter_seq: frame-level reference model, a small
// datapath stand-in that raises div_state, and a monitor popping expected errors.
module tb_adaptive_filter_seq;
  localparam int DW          = 14;
  localparam int TAPS        = 33;
  localparam int RUN_CYCLES  = 34;
  localparam int DIV_TIMEOUT = 64;
  localparam int NEVER       = 1000;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [DW-1:0]      s_data = '0;
  logic               filt_en;
  logic [TAPS*DW-1:0] taps_flat;
  logic               div_state = 1'b0;
  logic [DW-1:0]      e_in = '0;
  logic [DW-1:0]      e_out;
  logic               e_valid;
  logic               e_ready = 1'b0;
  logic               busy;
  logic               timeout_err;
  logic               err_clr = 1'b0;
  logic [15:0]        frame_cnt;

  adaptive_filter_seq #(.DW(DW), .TAPS(TAPS), .RUN_CYCLES(RUN_CYCLES),
                        .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .filt_en(filt_en), .taps_flat(taps_flat), .div_state(div_state), .e_in(e_in),
    .e_out(e_out), .e_valid(e_valid), .e_ready(e_ready), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mt [TAPS];
  logic [15:0]   mfc;
  bit            mte;
  logic [DW-1:0] exp_q [$];

  int div_delay  = NEVER;
  bit div_always = 1'b0;
  bit clr_at_to  = 1'b0;
  bit clr_req    = 1'b0;
  int en_run     = 0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [TAPS*DW-1:0] model_taps();
    logic [TAPS*DW-1:0] f;
    for (int k = 0; k < TAPS; k++) f[k*DW +: DW] = mt[k];
    return f;
  endfunction

  function automatic logic [DW-1:0] slot(input int k);
    return taps_flat[k*DW +: DW];
  endfunction

  // Datapath stand-in: div_state rises div_delay cycles into the divider wait.
  always begin
    @(negedge clk);
    #1;
    if (filt_en) en_run++; else en_run = 0;
    div_state = div_always || (filt_en && en_run >= RUN_CYCLES + 1 + div_delay);
    err_clr   = clr_req || (clr_at_to && filt_en && en_run == RUN_CYCLES + DIV_TIMEOUT);
  end

  // Monitor: every completed output handshake must match the oldest expectation.
  always begin
    logic [DW-1:0] v;
    @(negedge clk);
    #2;
    if (e_valid && e_ready && !rstn) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_e_valid", e_out, 0);
      end else begin
        v = exp_q.pop_front();
        chk(e_out == v, "e_out", e_out, v);
      end
    end
  end

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) mt[k] = '0;
    mfc = '0;
    mte = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    model_reset();
  endtask

  task automatic frame(input logic [DW-1:0] d, input logic [DW-1:0] e, input int dly,
                       input int rdy_lat, input bit hold, input bit clr_to);
    int  lat, en_cyc, vcnt, acc_cyc, guard;
    bit  completes, busy_ok;
    s_data = d; s_valid = 1'b1; e_in = e;
    div_delay = dly; clr_at_to = clr_to;
    e_ready = (rdy_lat == 0);
    guard = 0;
    while (!s_ready && guard < 200) begin @(negedge clk); guard++; end
    if (!s_ready) begin
      chk(1'b0, "accept_timeout", s_ready, 1);
      s_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(negedge clk);
    if (!hold) s_valid = 1'b0;
    for (int k = TAPS - 1; k > 0; k--) mt[k] = mt[k-1];
    mt[0] = d;
    completes = (dly < DIV_TIMEOUT);
    if (completes) exp_q.push_back(e);
    lat = -1; en_cyc = 0; vcnt = 0; busy_ok = 1'b1; guard = 0;
    while (!s_ready && guard < 400) begin
      if (filt_en) en_cyc++;
      if (!busy) busy_ok = 1'b0;
      if (e_valid) begin
        if (lat < 0) lat = cyc - acc_cyc;
        if (!e_ready) begin
          chk(e_out == e, "e_out_held", e_out, e);
          chk(frame_cnt == mfc, "frame_cnt_while_stalled", frame_cnt, mfc);
        end
        vcnt++;
        if (vcnt >= rdy_lat) e_ready = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    chk(s_ready, "return_to_idle", s_ready, 1);
    chk(busy_ok, "busy_during_frame", busy_ok, 1);
    if (completes) begin
      mfc = mfc + 16'd1;
      chk(lat == RUN_CYCLES + 3 + dly, "e_valid_latency", lat, RUN_CYCLES + 3 + dly);
      chk(en_cyc == RUN_CYCLES + dly + 2, "filt_en_cycles", en_cyc, RUN_CYCLES + dly + 2);
    end else begin
      mte = 1'b1;
      chk(lat == -1, "no_e_valid_on_timeout", lat, -1);
      chk(en_cyc == RUN_CYCLES + DIV_TIMEOUT, "filt_en_cycles_timeout", en_cyc,
          RUN_CYCLES + DIV_TIMEOUT);
    end
    clr_at_to = 1'b0;
    chk(!filt_en && !busy, "idle_outputs", {filt_en, busy}, 0);
    chk(frame_cnt == mfc, "frame_cnt", frame_cnt, mfc);
    chk(timeout_err == mte, "timeout_err", timeout_err, mte);
    chk(taps_flat == model_taps(), "taps", slot(0), mt[0]);
  endtask

  task automatic clear_err();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    mte = 1'b0;
    chk(timeout_err == 1'b0, "err_clr", timeout_err, 0);
  endtask

  initial begin
    int r, dly;
    do_reset();
    chk(s_ready == 1'b1, "rst_s_ready", s_ready, 1);
    chk(filt_en == 1'b0, "rst_filt_en", filt_en, 0);
    chk(e_valid == 1'b0 && busy == 1'b0, "rst_valid_busy", {e_valid, busy}, 0);
    chk(timeout_err == 1'b0, "rst_timeout_err", timeout_err, 0);
    chk(frame_cnt == 16'd0 && e_out == '0, "rst_counts", frame_cnt, 0);
    chk(taps_flat == '0, "rst_taps", slot(0), 0);

    for (int i = 1; i <= TAPS; i++) frame(DW'(i), DW'($urandom), 0, 0, 1'b0, 1'b0);
    chk(slot(0) == DW'(33), "fill_slot0", slot(0), 33);
    chk(slot(TAPS-1) == DW'(1), "fill_slot32", slot(TAPS-1), 1);
    chk(frame_cnt == 16'd33, "fill_frame_cnt", frame_cnt, 33);

    frame(DW'($urandom), 14'h1ABC, 2, 10, 1'b0, 1'b0);

    frame(DW'($urandom), DW'($urandom), NEVER, 0, 1'b0, 1'b0);
    clear_err();
    frame(DW'($urandom), DW'($urandom), NEVER, 0, 1'b0, 1'b1);
    clear_err();

    div_always = 1'b1;
    frame(DW'($urandom), DW'($urandom), 0, 1, 1'b0, 1'b0);
    div_always = 1'b0;

    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       dly = $urandom_range(0, 8);
      else if (r == 7) dly = DIV_TIMEOUT - 1;
      else if (r == 8) dly = DIV_TIMEOUT;
      else             dly = NEVER;
      frame(DW'($urandom), DW'($urandom), dly, $urandom_range(0, 3), 1'b0, 1'b0);
    end
    if (mte) clear_err();

    for (int i = 0; i < 3; i++)
      frame(DW'($urandom), DW'($urandom), $urandom_range(0, 4), 0, (i < 2), 1'b0);

    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    mfc = 16'hFFFF;
    frame(DW'($urandom), DW'($urandom), 1, 0, 1'b0, 1'b0);
    chk(frame_cnt == 16'h0000, "frame_cnt_wrap", frame_cnt, 0);

    s_data = DW'($urandom); s_valid = 1'b1; div_delay = 0;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (10) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    model_reset();
    chk(filt_en == 1'b0, "midrun_rst_filt_en", filt_en, 0);
    chk(taps_flat == '0, "midrun_rst_taps", slot(0), 0);
    chk(s_ready == 1'b1 && busy == 1'b0, "midrun_rst_ready_busy", {s_ready, busy}, 2);
    chk(frame_cnt == 16'd0, "midrun_rst_frame_cnt", frame_cnt, 0);
    frame(DW'($urandom), DW'($urandom), 3, 0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: cycle %0d, limit reached", cyc);
    $fatal(1, "[TB] global time limit");
  end
endmodule

// File: doc/adaptive_filter_seq.md
Name: adaptive_filter_seq

Overview:
Frame sequencer for the 33-tap adaptive-filter datapath. It accepts reference samples over a valid/ready handshake and maintains the tap delay line feeding the datapath's buffer inputs. For each sample it drives the datapath enable (adap_filter_state) through the MAC/accumulate window and waits for the divider's completion flag. It then captures the error output and presents it downstream over a valid/ready handshake. It also watches for a stalled divider.

Parameters:
DW, 14, sample/error width in bits
TAPS, 33, delay-line depth (datapath buffer inputs 0..TAPS-1)
RUN_CYCLES, 34, cycles filt_en is held in RUN (datapath counter 0..33)
DIV_TIMEOUT, 64, max WAIT_DIV cycles before abort

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset; synchronous, active-high (1 = reset)
s_valid  in  1  input sample valid
s_ready  out  1  sequencer can accept a sample
s_data  in  DW  reference sample
filt_en  out  1  drives datapath adap_filter_state
taps_flat  out  TAPS*DW  delay line; slot k = bits [k*DW +: DW], slot 0 newest
div_state  in  1  datapath divider result-valid flag
e_in  in  DW  datapath error output e
e_out  out  DW  captured error
e_valid  out  1  e_out valid
e_ready  in  1  downstream accepts e_out
busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky divider-timeout flag
err_clr  in  1  clears timeout_err
frame_cnt  out  16  completed frames, wraps 0xFFFF -> 0

Behaviour:
- Reset values: state IDLE; all taps 0; s_ready 1; filt_en 0; e_out 0; e_valid 0; busy 0; timeout_err 0; frame_cnt 0; run_cnt and wait_cnt 0. Reset wins over every other event and aborts any frame in progress.
- States: IDLE, RUN, WAIT_DIV, CAPTURE, OUT. All outputs are registered or decoded from state only; there is no input-to-output combinational path.
- IDLE
  - s_ready=1, filt_en=0.
  - On s_valid&s_ready: shift the delay line (slot k <= slot k-1 for k=TAPS-1..1; slot 0 <= s_data), clear run_cnt, go to RUN.
  - s_valid low: stay in IDLE; taps unchanged.
- RUN
  - filt_en=1, s_ready=0; run_cnt increments each cycle.
  - When run_cnt==RUN_CYCLES-1: clear wait_cnt, go to WAIT_DIV.
  - Taps are frozen from RUN through OUT.
- WAIT_DIV
  - filt_en=1.
  - If div_state==1: go to CAPTURE (checked before the timeout).
  - Else if wait_cnt==DIV_TIMEOUT-1: set timeout_err, go to IDLE (filt_en drops next cycle). No e_valid is issued and frame_cnt is not incremented.
  - Otherwise wait_cnt increments.
- CAPTURE
  - One cycle, filt_en=1, giving the datapath one cycle to register e.
  - e_out <= e_in at the end of this cycle; go to OUT.
- OUT
  - filt_en=0, so the datapath counter and accumulators clear. e_valid=1; e_out is held stable.
  - On e_ready: e_valid drops next cycle, frame_cnt increments (modulo 2^16), go to IDLE.
  - e_ready low: hold indefinitely.
- filt_en is therefore low for at least 2 cycles between frames (OUT, IDLE), which guarantees the datapath re-arms.
- Latency: with the sample accepted at edge T and div_state already high on entering WAIT_DIV, filt_en is high for T+1..T+RUN_CYCLES+2 and e_valid rises at T+RUN_CYCLES+3 (T+37 at defaults).
- timeout_err: set and err_clr in the same cycle -> set wins. err_clr otherwise clears the flag next cycle.
- s_valid held high during busy: not accepted; the sample must be held until s_ready.
- div_state high while in RUN: ignored; only sampled in WAIT_DIV.

Test Plan:
- Reset, then push 33 samples 1..33, each frame with div_state asserted on WAIT_DIV entry and e_ready=1. Required: slot 0=33, slot 32=1; e_valid first rises 37 cycles after the first accept; frame_cnt=33.
- Single frame with e_in=0x1ABC at CAPTURE and e_ready held low 10 cycles. Required: e_out=0x1ABC and e_valid=1 for all 10 cycles; frame_cnt increments only after e_ready; s_ready=0 until back in IDLE.
- div_state never asserted. Required: exactly 64 WAIT_DIV cycles, then timeout_err=1, filt_en=0, back to IDLE, e_valid never high, frame_cnt unchanged. Then err_clr=1 -> timeout_err=0 next cycle.
- Timeout and err_clr in the same cycle. Required: timeout_err=1.
- Assert rstn for 1 cycle mid-RUN (run_cnt=10). Required: next cycle filt_en=0, all taps=0, s_ready=1, busy=0, frame_cnt=0.
- Preload frame_cnt to 0xFFFF via 65535 frames (or force), complete one frame. Required: frame_cnt=0x0000. Also check: s_valid held high through a frame -> only one shift per frame.
